char_row_writer: RTL and testbench

//   Command-driven writer for a single character-row buffer. Accepts a byte

---
 rtl/char_row_writer.sv | 126 ++++++++++++
 tb/tb_char_row_writer.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/char_row_writer.sv
// char_row_writer
//   Command-driven writer for one character-row buffer. Host bytes arrive over a
//   valid/ready handshake and are decoded into cursor / write / fill operations.
//   Row-buffer writes are only issued while blank is high, so they never collide
//   with the pixel-scan reads of the row.
//
//   Command byte: [7:6] opcode, [5:0] argument
//     00 WRITE  write arg at the cursor, then advance the cursor (wraps)
//     01 SET    move the cursor to arg (rejected if arg >= NUM_CHARS)
//     10 FILL   write arg to every cell 0..NUM_CHARS-1, then cursor = 0
//     11        reserved, rejected
//
// Ports
//   clk       system clock, rising edge
//   rst       asynchronous active-high reset
//   rx_data   command byte from the host link
//   rx_valid  rx_data valid; host holds it until accepted
//   rx_ready  byte can be accepted this cycle (idle)
//   blank     video blanking; writes only permitted while high
//   wr_en     registered one-cycle write strobe to the row buffer
//   wr_addr   registered cell address for wr_en
//   wr_char   registered character code for wr_en
//   cursor    current write cursor
//   busy      a WRITE or FILL is in progress
//   err       registered one-cycle pulse: command rejected
module char_row_writer #(
    parameter int unsigned NUM_CHARS = 64,
    parameter int unsigned CHAR_W    = 6,
    parameter int unsigned ADDR_W    = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    input  logic              blank,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [CHAR_W-1:0] wr_char,
    output logic [ADDR_W-1:0] cursor,
    output logic              busy,
    output logic              err
);

    typedef enum logic [1:0] {StIdle, StPend, StFill} state_e;

    localparam logic [6:0]        NumChars = 7'(NUM_CHARS);
    localparam logic [ADDR_W-1:0] LastIdx  = ADDR_W'(NUM_CHARS - 1);

    state_e            state_q;
    logic [CHAR_W-1:0] char_q;
    logic [ADDR_W-1:0] fill_idx_q;
    logic [5:0]        arg;

    assign arg      = rx_data[5:0];
    assign rx_ready = (state_q == StIdle);
    assign busy     = (state_q != StIdle);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            char_q     <= '0;
            fill_idx_q <= '0;
            cursor     <= '0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_char    <= '0;
            err        <= 1'b0;
        end else begin
            // Strobes default low so each write/error is exactly one cycle.
            wr_en <= 1'b0;
            err   <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (rx_valid) begin
                        unique case (rx_data[7:6])
                            2'b00: begin
                                char_q  <= arg[CHAR_W-1:0];
                                state_q <= StPend;
                            end
                            2'b01: begin
                                if ({1'b0, arg} < NumChars) begin
                                    cursor <= arg[ADDR_W-1:0];
                                end else begin
                                    err <= 1'b1;
                                end
                            end
                            2'b10: begin
                                char_q     <= arg[CHAR_W-1:0];
                                fill_idx_q <= '0;
                                state_q    <= StFill;
                            end
                            default: err <= 1'b1;
                        endcase
                    end
                end
                StPend: begin
                    if (blank) begin
                        wr_en   <= 1'b1;
                        wr_addr <= cursor;
                        wr_char <= char_q;
                        cursor  <= (cursor == LastIdx) ? '0 : cursor + 1'b1;
                        state_q <= StIdle;
                    end
                end
                StFill: begin
                    // Pauses while blank is low and resumes at the same cell.
                    if (blank) begin
                        wr_en   <= 1'b1;
                        wr_addr <= fill_idx_q;
                        wr_char <= char_q;
                        if (fill_idx_q == LastIdx) begin
                            fill_idx_q <= '0;
                            cursor     <= '0;
                            state_q    <= StIdle;
                        end else begin
                            fill_idx_q <= fill_idx_q + 1'b1;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_char_row_writer.sv
module tb_char_row_writer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic       blank = 1'b1;
    logic       sel = 1'b0;   // 0: 64-cell DUT, 1: 40-cell DUT

    logic       rx_valid_a, rx_ready_a, wr_en_a, busy_a, err_a;
    logic [5:0] wr_addr_a, wr_char_a, cursor_a;
    logic       rx_valid_b, rx_ready_b, wr_en_b, busy_b, err_b;
    logic [5:0] wr_addr_b, wr_char_b, cursor_b;
    logic       rx_ready;

    assign rx_valid_a = rx_valid & ~sel;
    assign rx_valid_b = rx_valid & sel;
    assign rx_ready   = sel ? rx_ready_b : rx_ready_a;

    char_row_writer #(.NUM_CHARS(64), .CHAR_W(6), .ADDR_W(6)) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid_a),
        .rx_ready(rx_ready_a), .blank(blank), .wr_en(wr_en_a), .wr_addr(wr_addr_a),
        .wr_char(wr_char_a), .cursor(cursor_a), .busy(busy_a), .err(err_a)
    );

    char_row_writer #(.NUM_CHARS(40), .CHAR_W(6), .ADDR_W(6)) dut40 (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid_b),
        .rx_ready(rx_ready_b), .blank(blank), .wr_en(wr_en_b), .wr_addr(wr_addr_b),
        .wr_char(wr_char_b), .cursor(cursor_b), .busy(busy_b), .err(err_b)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int wr_cnt   = 0;
    int wr40_cnt = 0;
    int err_cnt  = 0;
    int err40_cnt = 0;
    logic [11:0] sb[$];   // expected {addr, char} of each row-buffer write

    // Scoreboard: every observed write must match the oldest expected one.
    always @(negedge clk) begin
        if (wr_en_a === 1'b1) begin
            logic [11:0] exp_w;
            wr_cnt++;
            n_checks++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_write: got addr=%0d char=%h, required no write",
                         wr_addr_a, wr_char_a);
            end else begin
                exp_w = sb.pop_front();
                if ({wr_addr_a, wr_char_a} !== exp_w) begin
                    n_fail++;
                    $display("FAIL write_data: got addr=%0d char=%h, required addr=%0d char=%h",
                             wr_addr_a, wr_char_a, exp_w[11:6], exp_w[5:0]);
                end
            end
        end
        if (wr_en_b === 1'b1) wr40_cnt++;
        if (err_a === 1'b1) err_cnt++;
        if (err_b === 1'b1) err40_cnt++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Call in the low clock phase; returns just after the accepting edge.
    task automatic send(input logic [7:0] b);
        int n = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        while (rx_ready !== 1'b1 && n < 1000) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n >= 1000) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: rx_ready=%b after %0d cycles, required 1", rx_ready, n);
        end
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic test_reset();
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({wr_en_a, wr_addr_a, wr_char_a, cursor_a, busy_a, err_a} !== 20'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: got wr_en=%b addr=%h char=%h cur=%h busy=%b err=%b, required all 0",
                     wr_en_a, wr_addr_a, wr_char_a, cursor_a, busy_a, err_a);
        end
        repeat (2) @(negedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        #1;
        n_checks++;
        if (rx_ready_a !== 1'b1 || busy_a !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: got rx_ready=%b busy=%b, required 1 0", rx_ready_a, busy_a);
        end
    endtask

    task automatic test_write_basic();
        int w0 = wr_cnt;
        blank = 1'b1;
        sb.push_back({6'd0, 6'h05});
        send(8'h05);
        sb.push_back({6'd1, 6'h07});
        @(negedge clk); #1;
        send(8'h07);
        repeat (4) @(negedge clk);
        #1;
        n_checks++;
        if (wr_cnt - w0 != 2 || cursor_a !== 6'd2) begin
            n_fail++;
            $display("FAIL write_basic: got writes=%0d cursor=%0d, required 2 2", wr_cnt - w0, cursor_a);
        end
    endtask

    task automatic test_blank_hold();
        int w0 = wr_cnt;
        blank = 1'b0;
        send(8'h0A);
        repeat (20) @(negedge clk);
        #1;
        n_checks++;
        if (wr_cnt != w0 || busy_a !== 1'b1 || rx_ready_a !== 1'b0) begin
            n_fail++;
            $display("FAIL blank_wait: got writes=%0d busy=%b rx_ready=%b, required 0 1 0",
                     wr_cnt - w0, busy_a, rx_ready_a);
        end
        sb.push_back({6'd2, 6'h0A});
        blank = 1'b1;
        @(negedge clk);
        #1;
        n_checks++;
        if (wr_cnt - w0 != 1 || busy_a !== 1'b0 || cursor_a !== 6'd3) begin
            n_fail++;
            $display("FAIL blank_release: got writes=%0d busy=%b cursor=%0d, required 1 0 3",
                     wr_cnt - w0, busy_a, cursor_a);
        end
    endtask

    task automatic test_cursor_wrap();
        int w0 = wr_cnt;
        int e0 = err_cnt;
        send(8'h7F);
        @(negedge clk); #1;
        n_checks++;
        if (cursor_a !== 6'd63 || err_cnt != e0) begin
            n_fail++;
            $display("FAIL set_63: got cursor=%0d errs=%0d, required 63 0", cursor_a, err_cnt - e0);
        end
        sb.push_back({6'd63, 6'h01});
        send(8'h01);
        repeat (2) @(negedge clk);
        #1;
        n_checks++;
        if (cursor_a !== 6'd0) begin
            n_fail++;
            $display("FAIL wrap_cursor: got cursor=%0d, required 0", cursor_a);
        end
        sb.push_back({6'd0, 6'h02});
        send(8'h02);
        repeat (2) @(negedge clk);
        #1;
        n_checks++;
        if (cursor_a !== 6'd1 || wr_cnt - w0 != 2 || err_cnt != e0) begin
            n_fail++;
            $display("FAIL after_wrap: got cursor=%0d writes=%0d errs=%0d, required 1 2 0",
                     cursor_a, wr_cnt - w0, err_cnt - e0);
        end
    endtask

    task automatic test_fill();
        int w0 = wr_cnt;
        int k = 0;
        bit ready_bad = 0;
        for (int i = 0; i < 64; i++) sb.push_back({6'(i), 6'h3F});
        blank = 1'b1;
        send(8'hBF);
        while (wr_cnt - w0 < 64 && k < 1000) begin
            blank = ((k % 5) < 3);
            @(negedge clk);
            #1;
            if (wr_cnt - w0 < 64 && rx_ready_a !== 1'b0) ready_bad = 1;
            k++;
        end
        blank = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        n_checks++;
        if (ready_bad) begin
            n_fail++;
            $display("FAIL fill_ready: got rx_ready=1 during fill, required 0");
        end
        n_checks++;
        if (wr_cnt - w0 != 64 || sb.size() != 0 || cursor_a !== 6'd0 || busy_a !== 1'b0) begin
            n_fail++;
            $display("FAIL fill_done: got writes=%0d pending=%0d cursor=%0d busy=%b, required 64 0 0 0",
                     wr_cnt - w0, sb.size(), cursor_a, busy_a);
        end
    endtask

    task automatic test_fill_reset();
        int w0 = wr_cnt;
        int k = 0;
        for (int i = 0; i < 64; i++) sb.push_back({6'(i), 6'h15});
        blank = 1'b1;
        send(8'h95);
        while (wr_cnt - w0 < 30 && k < 200) begin
            @(negedge clk);
            #1;
            k++;
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if (wr_en_a !== 1'b0 || busy_a !== 1'b0 || wr_cnt - w0 != 30) begin
            n_fail++;
            $display("FAIL fill_reset_now: got wr_en=%b busy=%b writes=%0d, required 0 0 30",
                     wr_en_a, busy_a, wr_cnt - w0);
        end
        sb.delete();
        repeat (2) @(negedge clk);
        #1 rst = 1'b0;
        repeat (10) @(negedge clk);
        #1;
        n_checks++;
        if (wr_cnt - w0 != 30 || busy_a !== 1'b0 || rx_ready_a !== 1'b1) begin
            n_fail++;
            $display("FAIL fill_reset_after: got writes=%0d busy=%b rx_ready=%b, required 30 0 1",
                     wr_cnt - w0, busy_a, rx_ready_a);
        end
    endtask

    task automatic test_errors();
        int w0 = wr_cnt;
        int e0 = err_cnt;
        int f0;
        send(8'hC0);
        repeat (3) @(negedge clk);
        #1;
        n_checks++;
        if (err_cnt - e0 != 1 || wr_cnt != w0 || busy_a !== 1'b0) begin
            n_fail++;
            $display("FAIL reserved_cmd: got err_cycles=%0d writes=%0d busy=%b, required 1 0 0",
                     err_cnt - e0, wr_cnt - w0, busy_a);
        end
        sel = 1'b1;
        f0 = err40_cnt;
        send(8'h45);
        @(negedge clk); #1;
        send(8'h68);
        repeat (2) @(negedge clk);
        #1;
        n_checks++;
        if (err40_cnt - f0 != 1 || cursor_b !== 6'd5) begin
            n_fail++;
            $display("FAIL set_out_of_range: got err_cycles=%0d cursor=%0d, required 1 5",
                     err40_cnt - f0, cursor_b);
        end
        send(8'h67);
        repeat (2) @(negedge clk);
        #1;
        n_checks++;
        if (err40_cnt - f0 != 1 || cursor_b !== 6'd39 || wr40_cnt != 0) begin
            n_fail++;
            $display("FAIL set_last: got err_cycles=%0d cursor=%0d writes=%0d, required 1 39 0",
                     err40_cnt - f0, cursor_b, wr40_cnt);
        end
        sel = 1'b0;
    endtask

    initial begin
        test_reset();
        test_write_basic();
        test_blank_hold();
        test_cursor_wrap();
        test_fill();
        test_fill_reset();
        test_errors();
        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
